// File: rtl/weight_mac_engine.sv
// Dot-product engine: streams N weight/feature pairs out of two registered-read
// memories, accumulates the signed products and emits one saturated result.
module weight_mac_engine #(
    parameter int N      = 30,
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int RELU   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDR_W-1:0]        w_address,
    output logic                     w_read,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0]        f_address,
    output logic                     f_read,
    input  logic signed [DATA_W-1:0] f_data,
    output logic                     busy,
    output logic signed [OUT_W-1:0]  result,
    output logic                     result_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX   = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN   = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

    state_t                     state_reg;
    logic [ADDR_W-1:0]          addr_reg;
    logic                       read_reg;
    logic                       valid_reg;
    logic signed [ACC_W-1:0]    acc_reg;
    logic signed [OUT_W-1:0]    result_reg;
    logic                       result_valid_reg;

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum_next;
    logic signed [OUT_W-1:0]    result_next;

    // valid_reg tracks which memory outputs carry real data; a zero read-back
    // is legitimate data and is never treated as "no data".
    assign product  = w_data * f_data;
    assign prod_ext = ACC_W'(product);
    assign sum_next = valid_reg ? (acc_reg + prod_ext) : acc_reg;

    always_comb begin
        result_next = sum_next[OUT_W-1:0];
        if (sum_next > OUT_MAX) begin
            result_next = OUT_MAX[OUT_W-1:0];
        end else if (sum_next < OUT_MIN) begin
            result_next = OUT_MIN[OUT_W-1:0];
        end
        if ((RELU != 0) && sum_next[ACC_W-1]) begin
            result_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            read_reg         <= 1'b0;
            valid_reg        <= 1'b0;
            acc_reg          <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            valid_reg        <= read_reg;
            result_valid_reg <= 1'b0;
            if (valid_reg) begin
                acc_reg <= sum_next;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        addr_reg  <= '0;
                        read_reg  <= 1'b1;
                        acc_reg   <= '0;
                    end
                end
                RUN: begin
                    // The last address is on the bus this cycle; stop reading
                    // so nothing beyond N-1 is ever requested.
                    if (addr_reg == LAST_ADDR) begin
                        state_reg <= DRAIN;
                        read_reg  <= 1'b0;
                        addr_reg  <= '0;
                    end else begin
                        addr_reg <= addr_reg + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state_reg        <= IDLE;
                    result_reg       <= result_next;
                    result_valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    read_reg  <= 1'b0;
                    addr_reg  <= '0;
                end
            endcase
        end
    end

    assign w_address    = addr_reg;
    assign f_address    = addr_reg;
    assign w_read       = read_reg;
    assign f_read       = read_reg;
    assign busy         = (state_reg != IDLE);
    assign result       = result_reg;
    assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_weight_mac_engine.sv
// Randomized and directed checks of weight_mac_engine against a dot-product
// model; two instances (RELU off/on) share the same memory contents.
module tb_weight_mac_engine;

    localparam int N = 30;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic [4:0]        w_address0, f_address0, w_address1, f_address1;
    logic              w_read0, f_read0, w_read1, f_read1;
    logic signed [8:0] w_data0, f_data0, w_data1, f_data1;
    logic              busy0, busy1, result_valid0, result_valid1;
    logic signed [15:0] result0, result1;

    logic signed [8:0] wmem [0:N-1];
    logic signed [8:0] fmem [0:N-1];

    int total = 0;
    int bad   = 0;
    int read_total  = 0;
    int valid_total = 0;
    int bad_read    = 0;
    int bad_addr    = 0;
    int bad_mirror  = 0;

    always #5 clk = ~clk;

    weight_mac_engine #(.N(N), .RELU(0)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .w_address(w_address0), .w_read(w_read0), .w_data(w_data0),
        .f_address(f_address0), .f_read(f_read0), .f_data(f_data0),
        .busy(busy0), .result(result0), .result_valid(result_valid0)
    );

    weight_mac_engine #(.N(N), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .start(start),
        .w_address(w_address1), .w_read(w_read1), .w_data(w_data1),
        .f_address(f_address1), .f_read(f_read1), .f_data(f_data1),
        .busy(busy1), .result(result1), .result_valid(result_valid1)
    );

    // Registered-read memories: data one edge after the address, 0 when not read.
    always @(posedge clk) begin
        w_data0 <= (w_read0 && w_address0 < 5'(N)) ? wmem[w_address0] : '0;
        f_data0 <= (f_read0 && f_address0 < 5'(N)) ? fmem[f_address0] : '0;
        w_data1 <= (w_read1 && w_address1 < 5'(N)) ? wmem[w_address1] : '0;
        f_data1 <= (f_read1 && f_address1 < 5'(N)) ? fmem[f_address1] : '0;
    end

    always @(negedge clk) begin
        if (w_read0) read_total <= read_total + 1;
        if (result_valid0) valid_total <= valid_total + 1;
        if ((w_read0 && !busy0) || (w_read1 && !busy1)) bad_read <= bad_read + 1;
        if ((w_read0 && w_address0 >= 5'(N)) || (w_read1 && w_address1 >= 5'(N)))
            bad_addr <= bad_addr + 1;
        if (w_address0 != f_address0 || w_read0 != f_read0 ||
            w_address1 != f_address1 || w_read1 != f_read1 ||
            w_address0 != w_address1 || result_valid0 != result_valid1)
            bad_mirror <= bad_mirror + 1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_result(input bit relu);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(wmem[k]) * int'(fmem[k]);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    // mode 0: plain run; 1: extra start pulses mid-run; 2: start held through result
    task automatic do_run(input string tag, input int mode);
        int n, busy_n, m, rd0, vd0, exp0, exp1;
        bit seen;
        exp0 = ref_result(0);
        exp1 = ref_result(1);
        rd0 = read_total;
        vd0 = valid_total;
        start = 1'b1;
        n = 0; busy_n = 0; seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (mode == 1) start = (n == 5 || n == 20);
            else if (mode == 0) start = 1'b0;
            if (busy0) busy_n++;
            if (result_valid0) seen = 1;
        end
        chk({tag, "_latency"}, n - 1, N + 1);
        chk({tag, "_busy_cycles"}, busy_n, N + 1);
        chk({tag, "_result"}, result0, exp0);
        chk({tag, "_result_relu"}, result1, exp1);
        $display("run %s: result=%0d relu=%0d latency=%0d", tag, result0, result1, n - 1);
        if (mode == 2) begin
            // start still high during the valid cycle: a second run starts at once
            @(negedge clk);
            start = 1'b0;
            m = 1; seen = 0;
            while (!seen && m < 200) begin
                @(negedge clk);
                m++;
                if (result_valid0) seen = 1;
            end
            chk({tag, "_b2b_latency"}, m - 1, N + 1);
            chk({tag, "_b2b_result"}, result0, exp0);
            $display("run %s second: result=%0d latency=%0d", tag, result0, m - 1);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_valid_pulses"}, valid_total - vd0, (mode == 2) ? 2 : 1);
        chk({tag, "_reads"}, read_total - rd0, (mode == 2) ? 2 * N : N);
        chk({tag, "_idle_busy"}, busy0, 0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            wmem[k] = 9'($urandom_range(0, 511));
            fmem[k] = 9'($urandom_range(0, 511));
        end
    endtask

    initial begin
        int vd;
        rst = 1'b1;
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            wmem[k] = 9'sd1;
            fmem[k] = 9'sd1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy0, 0);
        chk("reset_read", w_read0, 0);
        chk("reset_addr", w_address0, 0);
        chk("reset_result", result0, 0);
        chk("reset_valid", result_valid0, 0);

        do_run("ones", 0);
        chk("ones_const", result0, 30);

        for (int k = 0; k < N; k++) begin
            wmem[k] = (k % 2 == 0) ? 9'sd3 : -9'sd3;
            fmem[k] = 9'sd7;
        end
        do_run("alt3", 0);
        chk("alt3_const", result0, 0);

        for (int k = 0; k < N; k++) begin
            wmem[k] = 9'(k - 15);
            fmem[k] = 9'sd2;
        end
        do_run("ramp", 0);
        chk("ramp_const", result0, -30);

        for (int k = 0; k < N; k++) begin
            wmem[k] = 9'sd255;
            fmem[k] = 9'sd255;
        end
        do_run("satpos", 0);
        chk("satpos_const", result0, 32767);

        for (int k = 0; k < N; k++) begin
            wmem[k] = -9'sd256;
            fmem[k] = 9'sd255;
        end
        do_run("satneg", 0);
        chk("satneg_const", result0, -32768);
        chk("satneg_relu_const", result1, 0);

        for (int k = 0; k < N; k++) begin
            wmem[k] = 9'sd1;
            fmem[k] = 9'sd1;
        end
        do_run("glitch", 1);

        fill_random();
        do_run("hold", 2);

        // reset in the middle of a run leaves nothing behind
        for (int k = 0; k < N; k++) begin
            wmem[k] = 9'sd255;
            fmem[k] = 9'sd255;
        end
        vd = valid_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy0, 0);
        chk("midrst_read", w_read0 | f_read0, 0);
        chk("midrst_addr", w_address0 | f_address0, 0);
        chk("midrst_result", result0, 0);
        chk("midrst_valid", result_valid0, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_valid", valid_total - vd, 0);
        $display("run midrst: reset at cycle 12 of a run");
        for (int k = 0; k < N; k++) begin
            wmem[k] = 9'sd1;
            fmem[k] = 9'sd1;
        end
        do_run("after_rst", 0);
        chk("after_rst_const", result0, 30);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            do_run($sformatf("rand%0d", r), 0);
        end

        chk("never_addr_n", bad_addr, 0);
        chk("read_outside_run", bad_read, 0);
        chk("mirror_ports", bad_mirror, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
